// File: rtl/gmii_pkg.sv
// Shared constants and FSM state type for the GMII packet generator and
// related GMII blocks.
package gmii_pkg;

  localparam logic [7:0]  GMII_PRE      = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_IFG
  } gen_state_e;

endpackage

// File: rtl/gmii_crc32.sv
// Byte-wide Ethernet CRC32 (reflected) with a registered accumulator.
// crc_next_c is the accumulator advanced by data_i; crc_o is the stored value.
module gmii_crc32
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_next_c,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_next_c = crc32_byte(crc_q, data_i);
    crc_d      = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc_next_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_pkt_gen.sv
// Command-driven GMII rx-style frame generator: preamble, SFD, DA/SA/payload,
// optional CRC32 FCS and error injection, then a programmable inter-frame gap.
module gmii_pkt_gen
  import gmii_pkg::*;
#(
  parameter int unsigned LW      = 11,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned IFG     = 12,
  parameter int unsigned CRC_EN  = 1,
  parameter int unsigned PRE_LEN = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          c_srdy,
  output logic          c_drdy,
  input  logic [7:0]    c_src,
  input  logic [7:0]    c_dst,
  input  logic [LW-1:0] c_len,
  input  logic          c_err,
  output logic [7:0]    rxd,
  output logic          rx_dv,
  output logic          rx_er,
  output logic          busy,
  output logic [15:0]   pkt_count
);

  localparam int unsigned CW   = $clog2(MAX_LEN + PRE_LEN + IFG + 1);
  localparam int unsigned TAIL = (CRC_EN != 0) ? 5 : 1;

  gen_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, nxt_j;
  logic [CW-1:0] last_q, last_d;
  logic [7:0]    src_q, src_d, dst_q, dst_d;
  logic          err_q, err_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          dv_q, dv_d, er_q, er_d, busy_q, busy_d, drdy_q, drdy_d;
  logic [15:0]   pkt_q, pkt_d;
  logic          crc_init, crc_en;
  logic [31:0]   crc_next, crc_q;
  logic [31:0]   req_len, clamp_len;
  logic [CW-1:0] last_c;

  function automatic logic [7:0] data_byte(input logic [CW-1:0] j, input logic [7:0] src,
                                           input logic [7:0] dst);
    logic [7:0] b;
    b = 8'h00;
    if (j == CW'(5)) begin
      b = dst;
    end else if (j == CW'(11)) begin
      b = src;
    end else if (j >= CW'(12)) begin
      b = 8'(j - CW'(12));
    end
    return b;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
    return 8'(~crc >> {k, 3'b000});
  endfunction

  // Clamp requested length and precompute the index of the last DATA byte
  always_comb begin
    req_len = 32'(c_len);
    if (req_len < MIN_LEN) begin
      clamp_len = MIN_LEN;
    end else if (req_len > MAX_LEN) begin
      clamp_len = MAX_LEN;
    end else begin
      clamp_len = req_len;
    end
    last_c = CW'(clamp_len - TAIL);
  end

  gmii_crc32 u_crc (
    .clk        (clk),
    .reset_n    (reset_n),
    .init_i     (crc_init),
    .en_i       (crc_en),
    .data_i     (rxd_q),
    .crc_next_c (crc_next),
    .crc_o      (crc_q)
  );

  // Next state plus the registered output values for the cycle it enters.
  // The IDLE cycle with c_drdy high is the final cycle of the gap, so the
  // IFG state itself lasts IFG-1 cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    src_d    = src_q;
    dst_d    = dst_q;
    err_d    = err_q;
    rxd_d    = 8'h00;
    dv_d     = 1'b0;
    er_d     = 1'b0;
    pkt_d    = pkt_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    nxt_j    = cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (c_srdy && drdy_q) begin
          state_d  = ST_PRE;
          cnt_d    = '0;
          last_d   = last_c;
          src_d    = c_src;
          dst_d    = c_dst;
          err_d    = c_err;
          rxd_d    = GMII_PRE;
          dv_d     = 1'b1;
          crc_init = 1'b1;
        end
      end
      ST_PRE: begin
        dv_d = 1'b1;
        if (cnt_q == CW'(PRE_LEN - 1)) begin
          state_d = ST_SFD;
          rxd_d   = GMII_SFD;
        end else begin
          cnt_d = nxt_j;
          rxd_d = GMII_PRE;
        end
      end
      ST_SFD: begin
        state_d = ST_DATA;
        cnt_d   = '0;
        dv_d    = 1'b1;
        rxd_d   = data_byte('0, src_q, dst_q);
      end
      ST_DATA: begin
        crc_en = 1'b1;
        if (cnt_q != last_q) begin
          cnt_d = nxt_j;
          dv_d  = 1'b1;
          rxd_d = data_byte(nxt_j, src_q, dst_q);
          er_d  = err_q && (nxt_j == CW'(12));
        end else if (CRC_EN != 0) begin
          state_d = ST_FCS;
          cnt_d   = '0;
          dv_d    = 1'b1;
          rxd_d   = fcs_byte(crc_next, 2'd0);
        end else begin
          pkt_d   = pkt_q + 16'd1;
          cnt_d   = '0;
          state_d = (IFG > 1) ? ST_IFG : ST_IDLE;
        end
      end
      ST_FCS: begin
        if (cnt_q != CW'(3)) begin
          cnt_d = nxt_j;
          dv_d  = 1'b1;
          rxd_d = fcs_byte(crc_q, nxt_j[1:0]);
        end else begin
          pkt_d   = pkt_q + 16'd1;
          cnt_d   = '0;
          state_d = (IFG > 1) ? ST_IFG : ST_IDLE;
        end
      end
      ST_IFG: begin
        if (cnt_q == CW'(IFG - 2)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = nxt_j;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drdy_d = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      src_q   <= 8'h00;
      dst_q   <= 8'h00;
      err_q   <= 1'b0;
      rxd_q   <= 8'h00;
      dv_q    <= 1'b0;
      er_q    <= 1'b0;
      busy_q  <= 1'b0;
      drdy_q  <= 1'b1;
      pkt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
      rxd_q   <= rxd_d;
      dv_q    <= dv_d;
      er_q    <= er_d;
      busy_q  <= busy_d;
      drdy_q  <= drdy_d;
      pkt_q   <= pkt_d;
    end
  end

  assign c_drdy    = drdy_q;
  assign rxd       = rxd_q;
  assign rx_dv     = dv_q;
  assign rx_er     = er_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_q;

endmodule
